// File: rtl/fetch_assembler_pkg.sv
// Shared types and constants for the byte-serial instruction fetch path.
package asyn_arm_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int WAIT_CNT_W     = 8;

  localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int                DEF_ROM_WAIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAPTURE,
    ST_HOLD
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] byte_addr(input logic [WORD_W-1:0] pc,
                                                  input logic [1:0]        idx);
    return pc + {{(WORD_W-2){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/fetch_assembler_if.sv
// ROM request/response and decode handshake bundle for the fetch assembler.
interface fetch_assembler_if;
  import asyn_arm_pkg::*;

  logic [WORD_W-1:0] romAddr;
  logic              romTrigger;
  logic [BYTE_W-1:0] romData;
  logic              romReady;
  logic              branchValid;
  logic [WORD_W-1:0] branchTarget;
  logic              instrValid;
  logic              instrReady;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instrPc;

  modport master (
    output romAddr, romTrigger, instrValid, instr, instrPc,
    input  romData, romReady, branchValid, branchTarget, instrReady
  );

  modport slave (
    input  romAddr, romTrigger, instrValid, instr, instrPc,
    output romData, romReady, branchValid, branchTarget, instrReady
  );

endinterface

// File: rtl/fetch_assembler_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fetch_assembler.sv
// Assembles 32-bit little-endian instructions from a byte-wide, toggle-requested ROM.
//   state   | meaning
//   IDLE    | waiting for synchronized reset release
//   REQ     | present byte address, toggle romTrigger, arm wait counter
//   WAIT    | count down, then wait for synchronized romReady
//   CAPTURE | store byte (or drop it when flushing), advance byte index
//   HOLD    | complete word offered to decode until accepted or redirected
module fetch_assembler
  import asyn_arm_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int                ROM_WAIT = DEF_ROM_WAIT
) (
  input  logic              clk,
  input  logic              rstN,
  fetch_assembler_if.master bus
);

  fetch_state_e          state_q, state_d;
  logic [WORD_W-1:0]     pc_q, pc_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  trig_q, trig_d;
  logic [WORD_W-1:0]     rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0]     instr_q, instr_d;
  logic [WORD_W-1:0]     instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;
  logic                  flush_q, flush_d;
  logic                  ready_s;
  logic                  run_s;

  sync2 u_ready_sync (
    .clk   (clk),
    .rst_n (rstN),
    .d     (bus.romReady),
    .q     (ready_s)
  );

  // Release of rstN is retimed so the FSM never leaves IDLE on the release edge.
  sync2 u_rst_sync (
    .clk   (clk),
    .rst_n (rstN),
    .d     (1'b1),
    .q     (run_s)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    trig_d     = trig_q;
    rom_addr_d = rom_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    flush_d    = flush_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.branchValid) pc_d = bus.branchTarget;
        if (run_s) state_d = ST_REQ;
      end

      ST_REQ: begin
        rom_addr_d = byte_addr(pc_q, byte_idx_q);
        trig_d     = ~trig_q;
        cnt_d      = WAIT_CNT_W'(ROM_WAIT);
        state_d    = ST_WAIT;
        if (bus.branchValid) begin
          flush_d = 1'b1;
          pc_d    = bus.branchTarget;
        end
      end

      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end else if (ready_s) begin
          state_d = ST_CAPTURE;
        end
        if (bus.branchValid) begin
          flush_d = 1'b1;
          pc_d    = bus.branchTarget;
        end
      end

      ST_CAPTURE: begin
        // A redirect landing here also kills the byte being captured.
        if (flush_q || bus.branchValid) begin
          flush_d    = 1'b0;
          byte_idx_d = 2'd0;
          state_d    = ST_REQ;
          if (bus.branchValid) pc_d = bus.branchTarget;
        end else begin
          instr_d[{byte_idx_q, 3'b000} +: BYTE_W] = bus.romData;
          if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = ST_REQ;
          end
        end
      end

      ST_HOLD: begin
        if (bus.branchValid) begin
          valid_d    = 1'b0;
          pc_d       = bus.branchTarget;
          byte_idx_d = 2'd0;
          state_d    = ST_REQ;
        end else if (bus.instrReady) begin
          valid_d    = 1'b0;
          pc_d       = pc_q + WORD_W'(BYTES_PER_WORD);
          byte_idx_d = 2'd0;
          state_d    = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      byte_idx_q <= 2'd0;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      rom_addr_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      rom_addr_q <= rom_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.romAddr    = rom_addr_q;
  assign bus.romTrigger = trig_q;
  assign bus.instr      = instr_q;
  assign bus.instrPc    = instr_pc_q;
  assign bus.instrValid = valid_q;

endmodule

// File: doc/fetch_assembler.md
FETCH_ASSEMBLER -- requirements
Module: fetch_assembler

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ROM_WAIT, default 3, minimum clk cycles between romTrigger toggle and romReady sample.
REQ-003 clk  in  1  single clock, rising-edge.
REQ-004 rstN  in  1  reset, asynchronous, active-low.
REQ-005 romAddr  out  32  byte address presented to ROM.
REQ-006 romTrigger  out  1  transition-signalled request; every toggle is one ROM read.
REQ-007 romData  in  8  ROM byte, valid when romReady high after the request.
REQ-008 romReady  in  1  ROM completion, asynchronous to clk.
REQ-009 branchValid  in  1  one-cycle redirect strobe.
REQ-010 branchTarget  in  32  redirect address, word-aligned.
REQ-011 instrValid  out  1  instr/instrPc hold a complete word.
REQ-012 instrReady  in  1  decode accepts when instrValid and instrReady both high on a clk edge.
REQ-013 instr  out  32  assembled instruction, little-endian.
REQ-014 instrPc  out  32  byte address of instr byte 0.

Function
REQ-015 romReady SHALL pass through a 2-flop synchronizer before any use.
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, CAPTURE, HOLD.
REQ-017 IDLE: leaves to REQ on the first clk after reset release.
REQ-018 REQ: drive romAddr = pc + byteIdx, toggle romTrigger, load wait counter with ROM_WAIT, go WAIT; one cycle.
REQ-019 WAIT: decrement counter; when zero and synchronized ready = 1, go CAPTURE; otherwise stay.
REQ-020 CAPTURE: write romData into instr byte lane byteIdx (byte 0 -> bits 7:0); if byteIdx = 3 go HOLD with instrValid = 1, else byteIdx+1 and go REQ.
REQ-021 HOLD: instr, instrPc, instrValid stable until accepted; on accept pc += 4, byteIdx = 0, instrValid = 0, go REQ next cycle.
REQ-022 Read latency per word SHALL be 4 x (ROM_WAIT + 3) cycles minimum, ready synchronous.
REQ-023 romAddr SHALL be stable from REQ until the CAPTURE for that byte.
REQ-024 branchValid in HOLD: drop instrValid same edge, pc = branchTarget, byteIdx = 0, go REQ; a simultaneous accept is ignored (redirect wins).
REQ-025 branchValid in REQ/WAIT/CAPTURE: set flush flag, pc = branchTarget; the in-flight ROM read SHALL complete, its byte discarded, then byteIdx = 0 and go REQ; instrValid never asserted for a flushed word.
REQ-026 branchValid in IDLE: pc = branchTarget before first REQ.
REQ-027 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 Second branchValid during flush SHALL overwrite pc; last target wins.

Reset
REQ-029 While rstN = 0: state IDLE, pc = RESET_PC, byteIdx = 0, romTrigger = 0, romAddr = RESET_PC, instr = 0, instrPc = 0, instrValid = 0, flush = 0, synchronizer = 0.
REQ-030 Reset mid-transaction SHALL abandon the ROM read; no byte captured after reset release from the old request.
REQ-031 Reset release SHALL be synchronized internally; first REQ no earlier than the second clk after release.

Structure
REQ-032 Shared package asyn_arm_pkg SHALL hold the FSM state typedef, RESET_PC and ROM_WAIT defaults, word/byte width constants.
REQ-033 One sub-module, sync2 (2-flop synchronizer, async active-low reset), instantiated for romReady.

Verification
REQ-034 ROM holds 00 01 A0 E3 at 0..3, instrReady = 1 -> instr = 32'hE3A0_0100, instrPc = 0, instrValid one cycle, next romAddr = 4.
REQ-035 instrReady = 0 for 20 cycles with word valid -> instr/instrPc stable, romTrigger does not toggle.
REQ-036 branchValid with branchTarget = 32'h100 during WAIT of byte 2 -> exactly one further romReady consumed, no instrValid, next romAddr sequence 100,101,102,103.
REQ-037 branchValid and accept same edge in HOLD, target 32'h40 -> next instrPc = 32'h40, not pc+4.
REQ-038 RESET_PC = 32'hFFFF_FFFC, ROM model mod 1MB -> second word instrPc = 0.
REQ-039 rstN low during WAIT of byte 1 -> all outputs at REQ-029 values, restart at RESET_PC byte 0.
